// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Shared types and widths for the MIPS register-file write side.
//   DATA_W   : width of one register value
//   ADDR_W   : register index width (32 registers)
//   REG_ZERO : index of the hard-wired zero register; writes to it are dropped
//   wb_req_t : one pending register write {rd, data}
//   wb_src_e : which source loads the writeback output stage this cycle
//   fwd_t    : result of a forwarding lookup {hit, data}
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_MEM  = 2'd3
  } wb_src_e;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } fwd_t;

endpackage

// File: rtl/writeback_ctrl_if.sv
// -----------------------------------------------------------------------------
// writeback_ctrl_if
//   Bundles every non-clock signal of writeback_ctrl.
//   master : pipeline side (drives ALU/MEM results and lookup indices)
//   slave  : writeback_ctrl side (drives stall/ready, the register file write
//            port rd/dataIn/regWrite and the forwarding results)
// -----------------------------------------------------------------------------
interface writeback_ctrl_if;
  import mips_pkg::*;

  // ALU result source (single cycle)
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_stall;

  // MEM result source (valid/ready handshake)
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;

  // Register file write port
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] dataIn;
  logic              regWrite;

  // Forwarding lookup
  logic [ADDR_W-1:0] fwd_rs;
  logic [ADDR_W-1:0] fwd_rt;
  logic              fwd_rs_hit;
  logic [DATA_W-1:0] fwd_rs_data;
  logic              fwd_rt_hit;
  logic [DATA_W-1:0] fwd_rt_data;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           fwd_rs, fwd_rt,
    input  alu_stall, mem_ready, rd, dataIn, regWrite,
           fwd_rs_hit, fwd_rs_data, fwd_rt_hit, fwd_rt_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           fwd_rs, fwd_rt,
    output alu_stall, mem_ready, rd, dataIn, regWrite,
           fwd_rs_hit, fwd_rs_data, fwd_rt_hit, fwd_rt_data
  );

endinterface

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
//   Synchronous FIFO of pending register writes (wb_req_t). The caller never
//   pushes when full nor pops when empty.
//   clk, rst_n      : clock, asynchronous active-low reset (empties the FIFO)
//   i_push/i_req    : append i_req at the tail
//   i_pop           : drop the head entry
//   o_count         : number of valid entries
//   o_entries[i]    : entry i positions behind the head (index 0 is the head)
//   o_entry_valid[i]: o_entries[i] holds a live entry
// -----------------------------------------------------------------------------
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  wb_req_t                  i_req,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH):0]   o_count,
  output wb_req_t                  o_entries [DEPTH],
  output logic [DEPTH-1:0]         o_entry_valid
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  wb_req_t          r_mem [DEPTH];

  // Pointers are PTR_W bits wide and DEPTH is a power of 2, so plain
  // increment wraps modulo DEPTH.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; liveness comes from r_count, so
  // stale contents are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_tail] <= i_req;
  end

  assign o_count = r_count;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_entries[i]     = r_mem[r_head + PTR_W'(i)];
      o_entry_valid[i] = (i < int'(r_count));
    end
  end

endmodule

// File: rtl/writeback_ctrl.sv
// -----------------------------------------------------------------------------
// writeback_ctrl
//   Write side of the MIPS register file. Arbitrates the single-cycle ALU
//   result against variable-latency MEM results (buffered in wb_fifo), drives
//   the registered register-file write port and answers forwarding lookups for
//   values that are in flight but not yet in the file.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : writeback_ctrl_if.slave (ALU/MEM inputs, alu_stall,
//                mem_ready, rd/dataIn/regWrite, forwarding lookup)
//   FIFO_DEPTH   : MEM results that can wait (power of 2, >= 2)
//   STARVE_LIMIT : ALU wins a queued MEM result tolerates before forcing through
// -----------------------------------------------------------------------------
module writeback_ctrl
  import mips_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  writeback_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]      w_count;
  wb_req_t               w_entries [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] w_entry_valid;

  logic    w_fifo_ne, w_starve, w_mem_ready;
  logic    w_alu_ok, w_mem_ok, w_push, w_pop, w_cur_v;
  wb_src_e w_src;
  wb_req_t w_win_req;

  logic [AGE_W-1:0] r_age;
  logic             r_reg_write;
  wb_req_t          r_stage;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_push        (w_push),
    .i_req         ('{rd: bus.mem_rd, data: bus.mem_data}),
    .i_pop         (w_pop),
    .o_count       (w_count),
    .o_entries     (w_entries),
    .o_entry_valid (w_entry_valid)
  );

  // Readiness comes from the registered count only: a full FIFO refuses even
  // when its head drains this same cycle, keeping mem_ready free of any path
  // from the arbiter.
  assign w_fifo_ne   = (w_count != '0);
  assign w_mem_ready = (w_count < CNT_W'(FIFO_DEPTH));
  assign w_starve    = w_fifo_ne && (r_age == AGE_MAX);

  // Results targeting $0 are consumed but never staged or queued.
  assign w_alu_ok = bus.alu_valid && (bus.alu_rd != REG_ZERO);
  assign w_mem_ok = bus.mem_valid && w_mem_ready && (bus.mem_rd != REG_ZERO);

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    w_src     = SRC_NONE;
    w_win_req = '0;
    if (w_starve) begin
      w_src = SRC_FIFO;
    end else if (w_alu_ok) begin
      w_src = SRC_ALU;
    end else if (w_fifo_ne) begin
      w_src = SRC_FIFO;
    end else if (w_mem_ok) begin
      w_src = SRC_MEM;   // FIFO empty: bypass straight to the output stage
    end
    case (w_src)
      SRC_ALU:  w_win_req = '{rd: bus.alu_rd, data: bus.alu_data};
      SRC_MEM:  w_win_req = '{rd: bus.mem_rd, data: bus.mem_data};
      SRC_FIFO: w_win_req = w_entries[0];
      default:  w_win_req = '0;
    endcase
  end

  assign w_pop   = (w_src == SRC_FIFO);
  assign w_push  = w_mem_ok && (w_src != SRC_MEM);
  assign w_cur_v = (w_src == SRC_ALU) || (w_src == SRC_MEM);

  // Stall only while a starved head is being forced through; the ALU keeps
  // its operands for the next cycle.
  assign bus.alu_stall = w_starve;
  assign bus.mem_ready = w_mem_ready;

  // Age of the FIFO head in ALU wins; measured from the head, so any pop
  // restarts it for the next entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_age <= '0;
    end else if (w_pop || !w_fifo_ne) begin
      r_age <= '0;
    end else if ((w_src == SRC_ALU) && (r_age != AGE_MAX)) begin
      r_age <= r_age + 1'b1;
    end
  end

  // Output stage: rd/dataIn only load on a win and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write <= 1'b0;
      r_stage     <= '0;
    end else begin
      r_reg_write <= (w_src != SRC_NONE);
      if (w_src != SRC_NONE) r_stage <= w_win_req;
    end
  end

  assign bus.rd       = r_stage.rd;
  assign bus.dataIn   = r_stage.data;
  assign bus.regWrite = r_reg_write;

  // Youngest value wins: checks run oldest-first and later matches overwrite
  // (output stage, then FIFO head towards tail, then the current winner).
  function automatic fwd_t fwd_lookup(
    input logic [ADDR_W-1:0] idx,
    input wb_req_t           cur,
    input logic              cur_v,
    input wb_req_t           ent [FIFO_DEPTH],
    input logic [FIFO_DEPTH-1:0] ent_v,
    input wb_req_t           stg,
    input logic              stg_v
  );
    fwd_t res;
    res = '0;
    if (idx != REG_ZERO) begin
      if (stg_v && (stg.rd == idx)) res = '{hit: 1'b1, data: stg.data};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (ent_v[i] && (ent[i].rd == idx)) res = '{hit: 1'b1, data: ent[i].data};
      end
      if (cur_v && (cur.rd == idx)) res = '{hit: 1'b1, data: cur.data};
    end
    return res;
  endfunction

  fwd_t w_fwd_rs, w_fwd_rt;

  always_comb begin
    w_fwd_rs = fwd_lookup(bus.fwd_rs, w_win_req, w_cur_v, w_entries,
                          w_entry_valid, r_stage, r_reg_write);
    w_fwd_rt = fwd_lookup(bus.fwd_rt, w_win_req, w_cur_v, w_entries,
                          w_entry_valid, r_stage, r_reg_write);
  end

  assign bus.fwd_rs_hit  = w_fwd_rs.hit;
  assign bus.fwd_rs_data = w_fwd_rs.data;
  assign bus.fwd_rt_hit  = w_fwd_rt.hit;
  assign bus.fwd_rt_data = w_fwd_rt.data;

endmodule

// File: tb/tb_writeback_ctrl.sv
// -----------------------------------------------------------------------------
// tb_writeback_ctrl
//   Directed bench for writeback_ctrl (FIFO_DEPTH=2, STARVE_LIMIT=4).
//   Inputs change 1 time unit after the rising edge; registered outputs are
//   read at that point and combinational outputs 1 unit after inputs settle.
// -----------------------------------------------------------------------------
module tb_writeback_ctrl;

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  writeback_ctrl_if bus ();

  writeback_ctrl #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed no finish, required finish before 50000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_data  = d;
  endtask

  task automatic drive_mem(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.mem_valid = v;
    bus.mem_rd    = rd;
    bus.mem_data  = d;
  endtask

  task automatic idle();
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_mem(1'b0, 5'd0, 32'd0);
    bus.fwd_rs = 5'd0;
    bus.fwd_rt = 5'd0;
  endtask

  initial begin
    rst_n = 1'b1;
    idle();

    // ---- Reset values ----
    #1 rst_n = 1'b0;
    #2;
    check("rst_regwrite", 32'(bus.regWrite), 32'd0);
    check("rst_rd", 32'(bus.rd), 32'd0);
    check("rst_datain", bus.dataIn, 32'd0);
    check("rst_mem_ready", 32'(bus.mem_ready), 32'd1);
    check("rst_alu_stall", 32'(bus.alu_stall), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // ---- ALU only ----
    drive_alu(1'b1, 5'd9, 32'd10);
    settle();
    check("alu_stall_free", 32'(bus.alu_stall), 32'd0);
    tick();
    check("alu_rd", 32'(bus.rd), 32'd9);
    check("alu_datain", bus.dataIn, 32'd10);
    check("alu_regwrite", 32'(bus.regWrite), 32'd1);
    drive_alu(1'b0, 5'd0, 32'd0);
    tick();
    check("alu_regwrite_off", 32'(bus.regWrite), 32'd0);
    check("alu_rd_hold", 32'(bus.rd), 32'd9);
    check("alu_datain_hold", bus.dataIn, 32'd10);

    // ---- Collision: ALU first, MEM queued and written next cycle ----
    drive_alu(1'b1, 5'd10, 32'd12);
    drive_mem(1'b1, 5'd11, 32'd3);
    settle();
    check("col_mem_ready", 32'(bus.mem_ready), 32'd1);
    tick();
    check("col_alu_rd", 32'(bus.rd), 32'd10);
    check("col_alu_data", bus.dataIn, 32'd12);
    check("col_alu_we", 32'(bus.regWrite), 32'd1);
    idle();
    tick();
    check("col_mem_rd", 32'(bus.rd), 32'd11);
    check("col_mem_data", bus.dataIn, 32'd3);
    check("col_mem_we", 32'(bus.regWrite), 32'd1);
    tick();
    check("col_idle_we", 32'(bus.regWrite), 32'd0);

    // ---- Starvation: 4 ALU wins over a queued entry, then forced through ----
    drive_alu(1'b1, 5'd1, 32'd100);
    drive_mem(1'b1, 5'd2, 32'd200);
    tick();                                  // ALU wins, MEM queued (age 0)
    drive_mem(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("starve_no_stall", 32'(bus.alu_stall), 32'd0);
      tick();                                // ALU win i+1 over the queued entry
      check("starve_alu_rd", 32'(bus.rd), 32'd1);
    end
    settle();
    check("starve_stall", 32'(bus.alu_stall), 32'd1);
    tick();
    check("starve_mem_rd", 32'(bus.rd), 32'd2);
    check("starve_mem_data", bus.dataIn, 32'd200);
    settle();
    check("starve_stall_clear", 32'(bus.alu_stall), 32'd0);
    tick();
    check("starve_alu_after_rd", 32'(bus.rd), 32'd1);
    check("starve_alu_after_data", bus.dataIn, 32'd100);
    idle();
    tick();
    check("starve_idle_we", 32'(bus.regWrite), 32'd0);

    // ---- Full FIFO and writes to $0 ----
    drive_alu(1'b1, 5'd3, 32'd30);
    drive_mem(1'b1, 5'd4, 32'd40);
    tick();
    drive_mem(1'b1, 5'd5, 32'd50);
    tick();
    settle();
    check("full_mem_ready", 32'(bus.mem_ready), 32'd0);
    idle();
    tick();                                  // head (rd 4) drains
    check("full_pop1_rd", 32'(bus.rd), 32'd4);
    check("full_pop1_data", bus.dataIn, 32'd40);
    drive_mem(1'b1, 5'd0, 32'd99);
    settle();
    check("zero_mem_ready", 32'(bus.mem_ready), 32'd1);
    tick();                                  // rd 0 accepted and dropped
    check("full_pop2_rd", 32'(bus.rd), 32'd5);
    check("full_pop2_data", bus.dataIn, 32'd50);
    idle();
    tick();
    check("zero_never_written", 32'(bus.regWrite), 32'd0);
    settle();
    check("zero_fifo_empty", 32'(bus.mem_ready), 32'd1);

    // ---- Forwarding ----
    drive_alu(1'b1, 5'd9, 32'h111);
    drive_mem(1'b1, 5'd9, 32'h222);
    tick();                                  // stage 9=0x111, queue 9=0x222
    idle();
    bus.fwd_rs = 5'd9;
    bus.fwd_rt = 5'd0;
    settle();
    check("fwd_rs_hit_q", 32'(bus.fwd_rs_hit), 32'd1);
    check("fwd_rs_data_q", bus.fwd_rs_data, 32'h222);
    check("fwd_rt_hit_zero", 32'(bus.fwd_rt_hit), 32'd0);
    check("fwd_rt_data_zero", bus.fwd_rt_data, 32'd0);
    bus.fwd_rt = 5'd17;
    drive_alu(1'b1, 5'd9, 32'h333);
    settle();
    check("fwd_rs_data_cur", bus.fwd_rs_data, 32'h333);
    check("fwd_rt_hit_miss", 32'(bus.fwd_rt_hit), 32'd0);
    tick();                                  // stage 0x333, queue still 0x222
    drive_alu(1'b0, 5'd0, 32'd0);
    settle();
    check("fwd_rs_data_q2", bus.fwd_rs_data, 32'h222);
    tick();                                  // queue drains into stage
    settle();
    check("fwd_rs_hit_stage", 32'(bus.fwd_rs_hit), 32'd1);
    check("fwd_rs_data_stage", bus.fwd_rs_data, 32'h222);
    tick();
    check("fwd_stage_idle_we", 32'(bus.regWrite), 32'd0);
    check("fwd_rs_hit_none", 32'(bus.fwd_rs_hit), 32'd0);
    bus.fwd_rt = 5'd13;
    drive_mem(1'b1, 5'd13, 32'h55);
    settle();
    check("fwd_rt_hit_bypass", 32'(bus.fwd_rt_hit), 32'd1);
    check("fwd_rt_data_bypass", bus.fwd_rt_data, 32'h55);
    tick();                                  // MEM bypass, same latency as ALU
    check("bypass_rd", 32'(bus.rd), 32'd13);
    check("bypass_data", bus.dataIn, 32'h55);
    check("bypass_we", 32'(bus.regWrite), 32'd1);
    idle();

    // ---- Reset mid-burst with two queued entries ----
    drive_alu(1'b1, 5'd6, 32'd60);
    drive_mem(1'b1, 5'd7, 32'd70);
    tick();
    drive_mem(1'b1, 5'd8, 32'd80);
    tick();
    settle();
    check("burst_full", 32'(bus.mem_ready), 32'd0);
    check("burst_we", 32'(bus.regWrite), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(bus.regWrite), 32'd0);
    check("mid_rst_rd", 32'(bus.rd), 32'd0);
    check("mid_rst_data", bus.dataIn, 32'd0);
    check("mid_rst_ready", 32'(bus.mem_ready), 32'd1);
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_write", 32'(bus.regWrite), 32'd0);
    end
    check("post_rst_ready", 32'(bus.mem_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
